// File: rtl/fpu.sv
// fpu: multi-cycle IEEE-754 binary32 add / sub / mul unit.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous active-high reset (aborts any operation)
//   start          launch pulse; a, b, op sampled when unit is idle
//   op             000 add, 001 sub, 010 mul, others -> canonical NaN
//   a, b           binary32 operands
//   result         registered binary32 result, held until next completion
//   result_rdy_out one-cycle pulse when result is updated
//
// Pipeline through the FSM: IDLE (latch) -> UNPACK (classify, align/add or
// multiply) -> EXEC (normalize) -> ROUND (round, write result).
// Both datapaths meet in one 48-bit mantissa format whose binary point sits
// after bit 46, with value = m * 2^(e - 127 - 46).
module fpu (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        result_rdy_out
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, UNPACK, EXEC, ROUND} state_t;

   // unpack -> normalize
   typedef struct packed {
      logic               spec;      // special-case result, bypasses rounding
      logic [31:0]        spec_val;
      logic               sign;
      logic signed [10:0] e;
      logic [47:0]        m;
   } s1_t;

   // normalize -> round; exp is (biased exponent - 1) for normals, 0 for
   // subnormals, so adding the mantissa with its hidden bit restores it
   typedef struct packed {
      logic        spec;
      logic [31:0] spec_val;
      logic        sign;
      logic [7:0]  exp;
      logic [47:0] n;
   } s2_t;

   state_t      state, state_nxt;
   logic [31:0] a_q, b_q;
   logic [2:0]  op_q;
   s1_t         s1, s1_d;
   s2_t         s2, s2_d;

   function automatic logic [5:0] lzc48(input logic [47:0] v);
      lzc48 = 6'd48;
      for (int i = 0; i < 48; i++)
         if (v[i]) lzc48 = 6'(47 - i);
   endfunction

   // ---------------- FSM ----------------
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = UNPACK;
         UNPACK:  state_nxt = EXEC;
         EXEC:    state_nxt = ROUND;
         ROUND:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- UNPACK: classify, align+add or multiply ----------------
   logic        sa, sb, sbx, eff_sub, swap, is_add, is_mul;
   logic [7:0]  ea, eb, ea_e, eb_e, big_e, sml_e, d;
   logic [22:0] fa, fb;
   logic [23:0] ma, mb, big_m, sml_m;
   logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, big_s;
   logic [26:0] big_x, sml_x, sml_al;
   logic [27:0] sum;
   logic [47:0] prod;
   logic signed [10:0] e_mul;

   always_comb begin
      sa     = a_q[31];
      sb     = b_q[31];
      ea     = a_q[30:23];
      eb     = b_q[30:23];
      fa     = a_q[22:0];
      fb     = b_q[22:0];
      is_add = (op_q == 3'b000) || (op_q == 3'b001);
      is_mul = (op_q == 3'b010);
      nan_a  = (&ea) &&  (|fa);
      nan_b  = (&eb) &&  (|fb);
      inf_a  = (&ea) && !(|fa);
      inf_b  = (&eb) && !(|fb);
      zero_a = !(|a_q[30:0]);
      zero_b = !(|b_q[30:0]);
      // subnormals use effective exponent 1 with hidden bit 0
      ea_e   = (ea == 8'd0) ? 8'd1 : ea;
      eb_e   = (eb == 8'd0) ? 8'd1 : eb;
      ma     = {|ea, fa};
      mb     = {|eb, fb};

      // add/sub: larger magnitude first, smaller aligned with G/R/S
      sbx     = sb ^ op_q[0];
      eff_sub = sa ^ sbx;
      swap    = b_q[30:0] > a_q[30:0];
      big_s   = swap ? sbx  : sa;
      big_e   = swap ? eb_e : ea_e;
      big_m   = swap ? mb   : ma;
      sml_e   = swap ? ea_e : eb_e;
      sml_m   = swap ? ma   : mb;
      d       = big_e - sml_e;
      big_x   = {big_m, 3'b000};
      sml_x   = {sml_m, 3'b000};
      if (d >= 8'd26)
         sml_al = {26'd0, |sml_m};
      else
         sml_al = (sml_x >> d) | {26'd0, |(sml_x & ~({27{1'b1}} << d))};
      sum = eff_sub ? ({1'b0, big_x} - {1'b0, sml_al})
                    : ({1'b0, big_x} + {1'b0, sml_al});

      prod  = {24'd0, ma} * {24'd0, mb};
      e_mul = $signed({3'b000, ea_e}) + $signed({3'b000, eb_e}) - 11'sd127;

      s1_d          = '0;
      s1_d.spec_val = QNAN;
      if (is_add) begin
         if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
            s1_d.spec = 1'b1;
         end else if (inf_a) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_val = {sa, 8'hFF, 23'd0};
         end else if (inf_b) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_val = {sbx, 8'hFF, 23'd0};
         end else begin
            // exact zero: +0 on cancellation, operand sign when both zero
            s1_d.sign = (sum == 28'd0) ? (!eff_sub && sa) : big_s;
            s1_d.e    = $signed({3'b000, big_e});
            s1_d.m    = {sum, 20'd0};
         end
      end else if (is_mul) begin
         if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            s1_d.spec = 1'b1;
         end else if (inf_a || inf_b) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_val = {sa ^ sb, 8'hFF, 23'd0};
         end else begin
            s1_d.sign = sa ^ sb;
            s1_d.e    = e_mul;
            s1_d.m    = prod;
         end
      end else begin
         s1_d.spec = 1'b1;
      end
   end

   // ---------------- EXEC: normalize ----------------
   logic [5:0]         lz;
   logic signed [10:0] e_norm;
   logic [10:0]        rs;

   always_comb begin
      lz     = lzc48(s1.m);
      // biased exponent if the leading one were moved to bit 47
      e_norm = s1.e + 11'sd1 - $signed({5'd0, lz});
      rs     = 11'(-s1.e);

      s2_d          = '0;
      s2_d.spec     = s1.spec;
      s2_d.spec_val = s1.spec_val;
      s2_d.sign     = s1.sign;
      if (!s1.spec) begin
         if (s1.m == 48'd0) begin
            s2_d.spec     = 1'b1;
            s2_d.spec_val = {s1.sign, 31'd0};
         end else if (e_norm >= 11'sd255) begin
            s2_d.spec     = 1'b1;
            s2_d.spec_val = {s1.sign, 8'hFF, 23'd0};
         end else if (e_norm >= 11'sd1) begin
            s2_d.n   = s1.m << lz;
            s2_d.exp = 8'(e_norm - 11'sd1);
         end else if (!s1.e[10]) begin
            // subnormal: shift only as far as the exponent allows (e < lz)
            s2_d.n = s1.m << s1.e[5:0];
         end else if (rs >= 11'd48) begin
            s2_d.n = {47'd0, |s1.m};
         end else begin
            // exponent below 1: right shift, shifted-out bits fold into sticky
            s2_d.n = (s1.m >> rs) | {47'd0, |(s1.m & ~({48{1'b1}} << rs))};
         end
      end
   end

   // ---------------- ROUND: nearest-even ----------------
   logic        rnd_up;
   logic [30:0] packed_mag;

   always_comb begin
      rnd_up     = s2.n[23] && ((|s2.n[22:0]) || s2.n[24]);
      // carry out of the mantissa naturally bumps the exponent, including
      // subnormal->normal and max-finite->infinity
      packed_mag = {s2.exp, 23'd0} + {7'd0, s2.n[47:24]} + {30'd0, rnd_up};
   end

   // ---------------- registers ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         a_q            <= '0;
         b_q            <= '0;
         op_q           <= '0;
         s1             <= '0;
         s2             <= '0;
         result         <= '0;
         result_rdy_out <= 1'b0;
      end else begin
         result_rdy_out <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a_q  <= a;
               b_q  <= b;
               op_q <= op;
            end
            UNPACK: s1 <= s1_d;
            EXEC:   s2 <= s2_d;
            ROUND: begin
               result         <= s2.spec ? s2.spec_val : {s2.sign, packed_mag};
               result_rdy_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu.sv
// Scoreboard bench for fpu: each accepted operation pushes its expected
// result and completion cycle; the monitor pops and checks on every ready.
module tb_fpu;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [31:0] result;
   logic        result_rdy_out;

   fpu dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .op             (op),
      .a              (a),
      .b              (b),
      .result         (result),
      .result_rdy_out (result_rdy_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] exp;
      int          due;
      int          id;
   } sb_t;

   sb_t  q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_id    = 0;
   logic prev_rdy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // monitor: sample 1 time unit after the edge
   always @(posedge clock) begin
      #1;
      if (result_rdy_out) begin
         chk("rdy_pulse_width", {31'd0, prev_rdy}, 32'd0);
         if (q.size() == 0) begin
            chk("spurious_rdy", 32'd1, 32'd0);
         end else begin
            sb_t e;
            e = q.pop_front();
            chk($sformatf("res%0d", e.id), result, e.exp);
            chk($sformatf("lat%0d", e.id), 32'(cyc), 32'(e.due));
         end
      end
      prev_rdy <= result_rdy_out;
   end

   // drive at negedge; returns in the cycle where ready should be high,
   // so the next call asserts start back-to-back with the ready pulse
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp);
      sb_t e;
      start = 1'b1; op = o; a = x; b = y;
      e.exp = exp; e.due = cyc + 4; e.id = n_id;
      n_id++;
      q.push_back(e);
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   typedef struct {
      logic [2:0]  o;
      logic [31:0] x, y, r;
   } vec_t;

   vec_t vecs[] = '{
      '{3'b000, 32'h3F800000, 32'h40000000, 32'h40400000},
      '{3'b000, 32'h7F800000, 32'hFF800000, 32'h7FC00000},
      '{3'b000, 32'h7FC00001, 32'h3F800000, 32'h7FC00000},
      '{3'b000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
      '{3'b000, 32'h3F800000, 32'hBF800000, 32'h00000000},
      '{3'b000, 32'h80000000, 32'h80000000, 32'h80000000},
      '{3'b000, 32'h00000000, 32'h80000000, 32'h00000000},
      '{3'b000, 32'h00000001, 32'h00000001, 32'h00000002},
      '{3'b000, 32'h4B800000, 32'h3F800000, 32'h4B800000},
      '{3'b000, 32'h4B800001, 32'h3F800000, 32'h4B800002},
      '{3'b000, 32'hFF800000, 32'h3F800000, 32'hFF800000},
      '{3'b010, 32'h40000000, 32'h40400000, 32'h40C00000},
      '{3'b010, 32'h00000000, 32'hFF800000, 32'h7FC00000},
      '{3'b010, 32'h00800000, 32'h3F000000, 32'h00400000},
      '{3'b010, 32'h7F000000, 32'h40000000, 32'h7F800000},
      '{3'b010, 32'h00000001, 32'h3F000000, 32'h00000000},
      '{3'b010, 32'h00000003, 32'h3F000000, 32'h00000002},
      '{3'b010, 32'h80000001, 32'h3F000000, 32'h80000000},
      '{3'b010, 32'h7F800000, 32'hC0000000, 32'hFF800000},
      '{3'b001, 32'h40400000, 32'h3F800000, 32'h40000000},
      '{3'b001, 32'h7F800000, 32'h7F800000, 32'h7FC00000},
      '{3'b001, 32'h3F800000, 32'h3F800000, 32'h00000000},
      '{3'b001, 32'h00800001, 32'h00800000, 32'h00000001},
      '{3'b011, 32'h3F800000, 32'h3F800000, 32'h7FC00000}
   };

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clock);
      chk("reset_result", result, 32'h0);
      chk("reset_rdy", {31'd0, result_rdy_out}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      foreach (vecs[i]) issue(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].r);
      repeat (2) @(negedge clock);

      // start while busy is ignored: one pulse with the first operands' result
      begin
         sb_t e;
         start = 1'b1; op = 3'b000; a = 32'h40000000; b = 32'h40000000;
         e.exp = 32'h40800000; e.due = cyc + 4; e.id = n_id;
         n_id++;
         q.push_back(e);
         @(negedge clock);
         op = 3'b010; a = 32'h40400000; b = 32'h40400000;
         @(negedge clock);
         start = 1'b0;
         repeat (6) @(negedge clock);
      end

      // reset one cycle after start aborts: no pulse, result cleared
      start = 1'b1; op = 3'b000; a = 32'h3F800000; b = 32'h3F800000;
      @(negedge clock);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (6) @(negedge clock);
      chk("abort_result", result, 32'h0);

      // drain with a bound
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clock);
      chk("drain", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
